// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scanner: segment patterns (a..g, 0 = lit) and parameter bounds.
`default_nettype none

package seven_seg_pkg;

  localparam int DIGITS_MIN      = 1;
  localparam int DIGITS_MAX      = 8;
  localparam int REFRESH_DIV_MIN = 4;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0000010;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b1110010;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0010000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

`default_nettype wire

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low a..g segment pattern decoder.
`default_nettype none

module hex_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = SEG_BLANK;
    case (nibble)
      4'h0: pattern = SEG_0;
      4'h1: pattern = SEG_1;
      4'h2: pattern = SEG_2;
      4'h3: pattern = SEG_3;
      4'h4: pattern = SEG_4;
      4'h5: pattern = SEG_5;
      4'h6: pattern = SEG_6;
      4'h7: pattern = SEG_7;
      4'h8: pattern = SEG_8;
      4'h9: pattern = SEG_9;
      4'hA: pattern = SEG_A;
      4'hB: pattern = SEG_B;
      4'hC: pattern = SEG_C;
      4'hD: pattern = SEG_D;
      4'hE: pattern = SEG_E;
      4'hF: pattern = SEG_F;
      default: pattern = SEG_BLANK;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seven_seg_scanner.sv
// Multiplexed seven-segment scanner with a dead cycle between digit slots.
// Optional leading-zero blanking is compiled in with macro SEVEN_SEG_LZ_BLANK_EN.
`default_nettype none

module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int DIGITS      = 4,       // 1..8
  parameter int REFRESH_DIV = 100000   // >= 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  blank_en,
  output logic [7:0]            segs,
  output logic [DIGITS-1:0]     an
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  logic [4*DIGITS-1:0] shadow_val;
  logic [DIGITS-1:0]   shadow_dp;

  logic                tick;
  logic                dead;
  logic [3:0]          nibble;
  logic                dp_bit;
  logic [6:0]          pattern;
  logic                blank_digit;

  assign tick = (cnt == CNT_W'(REFRESH_DIV - 1));
  // Counter value 0 is the slot right after a tick; its registered image is the dead cycle.
  assign dead = (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (tick) begin
      cnt <= '0;
      idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
    end else if (load) begin
      shadow_val <= value;
      shadow_dp  <= dp_in;
    end
  end

  always_comb begin
    nibble = 4'h0;
    dp_bit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        nibble = shadow_val[i*4 +: 4];
        dp_bit = shadow_dp[i];
      end
    end
  end

  hex_to_seg u_hex_to_seg (
    .nibble  (nibble),
    .pattern (pattern)
  );

`ifdef SEVEN_SEG_LZ_BLANK_EN
  logic nz_at_or_above;

  // A digit is a leading zero when it and every higher nibble are zero; digit 0 always shows.
  always_comb begin
    nz_at_or_above = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if ((i >= int'(idx)) && (shadow_val[i*4 +: 4] != 4'h0)) begin
        nz_at_or_above = 1'b1;
      end
    end
    blank_digit = blank_en && !nz_at_or_above && (idx != '0);
  end
`else
  logic unused_blank_en;
  assign unused_blank_en = blank_en;
  assign blank_digit     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      segs <= 8'hFF;
      an   <= '1;
    end else if (dead) begin
      segs <= 8'hFF;
      an   <= '1;
    end else begin
      segs <= {(blank_digit ? SEG_BLANK : pattern), ~dp_bit};
      an   <= ~(DIGITS'(1) << idx);
    end
  end

endmodule

`default_nettype wire
